icache_req_arb: RTL and testbench

ICACHE_REQ_ARB -- requirements
Module: icache_req_arb

---
 rtl/icache_req_arb.sv | 152 +++++++++++++++
 tb/tb_icache_req_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_req_arb.sv
// ICache request arbiter: demand vs prefetch onto one ICache port; optional prefetch path under ICACHE_ARB_PREFETCH_EN.
// Latency: requests and responses pass through combinationally, one request outstanding at a time.
// Backpressure: ready_o follows ic_req_ready_i for the winner only; responses are never buffered.

package config_pkg;
    typedef struct packed {
        int unsigned VLEN;
        int unsigned ILEN;
        int unsigned INSTR_PER_FETCH;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{VLEN: 32, ILEN: 32, INSTR_PER_FETCH: 4};
endpackage

module icache_req_arb #(
    parameter config_pkg::cfg_t Cfg          = config_pkg::EmptyCfg,
    parameter int unsigned      STARVE_LIMIT = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      dmd_req_valid_i,
    output logic                                      dmd_req_ready_o,
    input  logic [Cfg.VLEN-1:0]                       dmd_req_addr_i,
    output logic                                      dmd_rsp_valid_o,
    output logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]   dmd_rsp_data_o,
    input  logic                                      pf_req_valid_i,
    output logic                                      pf_req_ready_o,
    input  logic [Cfg.VLEN-1:0]                       pf_req_addr_i,
    output logic                                      pf_done_o,
    output logic                                      ic_req_valid_o,
    input  logic                                      ic_req_ready_i,
    output logic [Cfg.VLEN-1:0]                       ic_req_addr_o,
    input  logic                                      ic_rsp_valid_i,
    input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]   ic_rsp_data_i,
    input  logic                                      flush_i
);

    localparam int unsigned VLEN = Cfg.VLEN;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RSP = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    state_t state;
    logic   owner;

    logic idle_ok;
    logic pf_ic;
    logic pf_acc_filt;
    logic dmd_ic;
    logic dmd_grant;
    logic pf_grant;
    logic rsp_here;

    // Gating with rst_n keeps every request-side output low while reset is held.
    assign idle_ok = rst_n && (state == S_IDLE) && !flush_i;

`ifdef ICACHE_ARB_PREFETCH_EN
    localparam int unsigned GRP_LSB = $clog2(Cfg.INSTR_PER_FETCH * Cfg.ILEN / 8);
    localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);

    logic [3:0]              starve_cnt;
    logic [VLEN-1-GRP_LSB:0] last_grp;
    logic                    last_grp_vld;
    logic                    starved;
    logic                    pf_filt;
    logic                    pf_sel;

    assign starved     = (starve_cnt == LIMIT);
    assign pf_filt     = last_grp_vld && (pf_req_addr_i[VLEN-1:GRP_LSB] == last_grp);
    assign pf_sel      = pf_req_valid_i && (!dmd_req_valid_i || starved);
    assign pf_ic       = pf_sel && !pf_filt;
    // A filtered prefetch retires without touching the ICache, so a demand may still use the port.
    assign pf_acc_filt = idle_ok && pf_sel && pf_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt   <= 4'd0;
            last_grp     <= '0;
            last_grp_vld <= 1'b0;
        end else begin
            if (pf_grant || pf_acc_filt) begin
                starve_cnt <= 4'd0;
            end else if (dmd_grant && pf_req_valid_i && !starved) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if (flush_i) begin
                last_grp_vld <= 1'b0;
            end else if (dmd_grant) begin
                last_grp_vld <= 1'b1;
                last_grp     <= dmd_req_addr_i[VLEN-1:GRP_LSB];
            end
        end
    end
`else
    logic unused_pf;

    assign unused_pf   = ^{pf_req_valid_i, pf_req_addr_i, STARVE_LIMIT};
    assign pf_ic       = 1'b0;
    assign pf_acc_filt = 1'b0;
`endif

    assign dmd_ic    = dmd_req_valid_i && !pf_ic;
    assign dmd_grant = idle_ok && dmd_ic && ic_req_ready_i;
    assign pf_grant  = idle_ok && pf_ic && ic_req_ready_i;
    assign rsp_here  = (state == S_WAIT_RSP) && ic_rsp_valid_i;

    assign ic_req_valid_o  = idle_ok && (dmd_ic || pf_ic);
    assign ic_req_addr_o   = pf_ic ? pf_req_addr_i : dmd_req_addr_i;
    assign dmd_req_ready_o = dmd_grant;
    assign pf_req_ready_o  = pf_grant || pf_acc_filt;

    // A flush landing with the demand response kills it in the same cycle.
    assign dmd_rsp_valid_o = rsp_here && !owner && !flush_i;
    assign dmd_rsp_data_o  = ic_rsp_data_i;
    assign pf_done_o       = pf_acc_filt || (rsp_here && owner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            owner <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dmd_grant || pf_grant) begin
                        state <= S_WAIT_RSP;
                        owner <= pf_grant;
                    end
                end
                S_WAIT_RSP: begin
                    if (ic_rsp_valid_i) begin
                        state <= S_IDLE;
                    end else if (flush_i && !owner) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ic_rsp_valid_i) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_req_arb.sv
// Bench for icache_req_arb: cycle-script table plus a grant-order / response-data scoreboard.
module tb_icache_req_arb;

`ifdef ICACHE_ARB_PREFETCH_EN
    localparam logic PF = 1'b1;
`else
    localparam logic PF = 1'b0;
`endif

    localparam logic [31:0] A = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dmd_req_valid;
    logic         dmd_req_ready;
    logic [31:0]  dmd_req_addr;
    logic         dmd_rsp_valid;
    logic [127:0] dmd_rsp_data;
    logic         pf_req_valid;
    logic         pf_req_ready;
    logic [31:0]  pf_req_addr;
    logic         pf_done;
    logic         ic_req_valid;
    logic         ic_req_ready;
    logic [31:0]  ic_req_addr;
    logic         ic_rsp_valid;
    logic [127:0] ic_rsp_data;
    logic         flush;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    icache_req_arb dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dmd_req_valid_i (dmd_req_valid),
        .dmd_req_ready_o (dmd_req_ready),
        .dmd_req_addr_i  (dmd_req_addr),
        .dmd_rsp_valid_o (dmd_rsp_valid),
        .dmd_rsp_data_o  (dmd_rsp_data),
        .pf_req_valid_i  (pf_req_valid),
        .pf_req_ready_o  (pf_req_ready),
        .pf_req_addr_i   (pf_req_addr),
        .pf_done_o       (pf_done),
        .ic_req_valid_o  (ic_req_valid),
        .ic_req_ready_i  (ic_req_ready),
        .ic_req_addr_o   (ic_req_addr),
        .ic_rsp_valid_i  (ic_rsp_valid),
        .ic_rsp_data_i   (ic_rsp_data),
        .flush_i         (flush)
    );

    typedef struct {
        logic         fl, dv;
        logic [31:0]  da;
        logic         pv;
        logic [31:0]  pa;
        logic         ir, rv;
        logic [127:0] rd;
        logic         e_icv;
        logic [31:0]  e_ia;
        logic         e_dr, e_pr, e_pd, e_drv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic dv, input logic [31:0] da,
                                input logic pv, input logic [31:0] pa, input logic ir,
                                input logic rv, input logic [127:0] rd, input logic e_icv,
                                input logic [31:0] e_ia, input logic e_dr, input logic e_pr,
                                input logic e_pd, input logic e_drv);
        vec_t v;
        v.fl = fl; v.dv = dv; v.da = da; v.pv = pv; v.pa = pa; v.ir = ir; v.rv = rv; v.rd = rd;
        v.e_icv = e_icv; v.e_ia = e_ia; v.e_dr = e_dr; v.e_pr = e_pr; v.e_pd = e_pd;
        v.e_drv = e_drv;
        return v;
    endfunction

    function automatic logic [127:0] data_of(input logic [31:0] addr);
        return {addr, ~addr, addr ^ 32'h5a5a_5a5a, 32'hc0ff_ee00};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ic_req_valid"}, ic_req_valid, 0);
        chk({tag, " dmd_req_ready"}, dmd_req_ready, 0);
        chk({tag, " pf_req_ready"}, pf_req_ready, 0);
        chk({tag, " pf_done"}, pf_done, 0);
        chk({tag, " dmd_rsp_valid"}, dmd_rsp_valid, 0);
    endtask

    task automatic drive(input vec_t v);
        flush = v.fl; dmd_req_valid = v.dv; dmd_req_addr = v.da;
        pf_req_valid = v.pv; pf_req_addr = v.pa; ic_req_ready = v.ir;
        ic_rsp_valid = v.rv; ic_rsp_data = v.rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp_own[$];
        logic [127:0] exp_dat[$];
        logic [31:0] cur_da, cur_pa, pend_addr;
        logic pend, pend_own, o;

        // Reset held with live requests on every input: nothing may leak out.
        rst_n = 1'b0; flush = 1'b0;
        dmd_req_valid = 1'b1; dmd_req_addr = A; pf_req_valid = 1'b1; pf_req_addr = 32'h9000_0000;
        ic_req_ready = 1'b1; ic_rsp_valid = 1'b1; ic_rsp_data = '1;
        #12;
        chk_all_zero("reset");
        dmd_req_valid = 1'b0; pf_req_valid = 1'b0; ic_rsp_valid = 1'b0; ic_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        //           fl dv da        pv pa        ir rv rd                      icv ia        dr pr  pd  drv
        vecs.push_back(mk(0, 0, 0,        0, 0,        0, 0, 0,                  0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 1, A,        0, 0,        1, 0, 0,                  1,  A,        1, 0,  0,  0));
        vecs.push_back(mk(0, 1, A+'h40,   0, 0,        0, 0, 0,                  0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 1, A+'h40,   0, 0,        0, 0, 0,                  0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 1, A+'h40,   0, 0,        0, 1, {4{32'ha1a1_0001}}, 0,  0,        0, 0,  0,  1));
        vecs.push_back(mk(0, 1, A+'h40,   0, 0,        0, 0, 0,                  1,  A+'h40,   0, 0,  0,  0));
        vecs.push_back(mk(0, 1, A+'h40,   0, 0,        1, 0, 0,                  1,  A+'h40,   1, 0,  0,  0));
        vecs.push_back(mk(1, 0, 0,        0, 0,        0, 0, 0,                  0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 1, A+'h80,   0, 0,        1, 0, 0,                  0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 1, A+'h80,   0, 0,        1, 1, {4{32'hb2b2_0002}}, 0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 1, A+'h80,   0, 0,        1, 0, 0,                  1,  A+'h80,   1, 0,  0,  0));
        vecs.push_back(mk(1, 0, 0,        0, 0,        0, 1, {4{32'hc3c3_0003}}, 0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 1, A+'h90,   0, 0,        1, 0, 0,                  1,  A+'h90,   1, 0,  0,  0));
        vecs.push_back(mk(0, 0, 0,        0, 0,        0, 1, {4{32'hd4d4_0004}}, 0,  0,        0, 0,  0,  1));
        vecs.push_back(mk(1, 1, A+'ha0,   0, 0,        1, 0, 0,                  0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 0, 0,        0, 0,        1, 1, {4{32'he5e5_0005}}, 0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 1, A+'h10,   0, 0,        1, 0, 0,                  1,  A+'h10,   1, 0,  0,  0));
        vecs.push_back(mk(0, 0, 0,        0, 0,        0, 1, {4{32'hf6f6_0006}}, 0,  0,        0, 0,  0,  1));
        vecs.push_back(mk(0, 0, 0,        1, A+'h18,   1, 0, 0,                  0,  0,        0, PF, PF, 0));
        vecs.push_back(mk(0, 0, 0,        1, A+'h20,   1, 0, 0,                  PF, A+'h20,   0, PF, 0,  0));
        vecs.push_back(mk(1, 0, 0,        0, 0,        0, 0, 0,                  0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 0, 0,        0, 0,        0, 1, {4{32'h1717_0007}}, 0,  0,        0, 0,  PF, 0));
        vecs.push_back(mk(0, 0, 0,        1, A+'h18,   0, 0, 0,                  PF, A+'h18,   0, 0,  0,  0));
        vecs.push_back(mk(0, 0, 0,        0, 0,        0, 0, 0,                  0,  0,        0, 0,  0,  0));
        vecs.push_back(mk(0, 1, A+'h100,  1, 32'h9000_0000, 1, 0, 0,             1,  A+'h100,  1, 0,  0,  0));
        vecs.push_back(mk(0, 0, 0,        0, 0,        0, 1, {4{32'h2828_0008}}, 0,  0,        0, 0,  0,  1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            #4;
            chk($sformatf("v%0d ic_req_valid", i), ic_req_valid, vecs[i].e_icv);
            if (vecs[i].e_icv) chk($sformatf("v%0d ic_req_addr", i), ic_req_addr, vecs[i].e_ia);
            chk($sformatf("v%0d dmd_req_ready", i), dmd_req_ready, vecs[i].e_dr);
            chk($sformatf("v%0d pf_req_ready", i), pf_req_ready, vecs[i].e_pr);
            chk($sformatf("v%0d pf_done", i), pf_done, vecs[i].e_pd);
            chk($sformatf("v%0d dmd_rsp_valid", i), dmd_rsp_valid, vecs[i].e_drv);
            if (vecs[i].e_drv) chk($sformatf("v%0d dmd_rsp_data", i), dmd_rsp_data, vecs[i].rd);
        end

        // Reset asserted while a demand is outstanding, then released between edges.
        @(posedge clk);
        #1 drive(mk(0, 1, A+'h300, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #4 chk("r35 grant", dmd_req_ready, 1);
        @(posedge clk);
        #1 ic_rsp_valid = 1'b1; ic_rsp_data = data_of(A+'h300); rst_n = 1'b0;
        #1 chk_all_zero("r35 in reset");
        #2 ic_rsp_valid = 1'b0; rst_n = 1'b1;
        #1 chk("r35 release valid", ic_req_valid, 1);
        chk("r35 release ready", dmd_req_ready, 1);
        @(posedge clk);
        #1 chk("r35 granted at first edge", dmd_req_ready, 0);
        ic_rsp_valid = 1'b1;
        #1 chk("r35 rsp valid", dmd_rsp_valid, 1);
        chk("r35 rsp data", dmd_rsp_data, data_of(A+'h300));

        // Both requesters valid every cycle; ICache answers the cycle after each grant.
        for (int i = 0; i < 10; i++) exp_own.push_back(PF && (i % 5 == 4));
        cur_da = A + 'h1000; cur_pa = 32'h9000_0000; pend = 1'b0; pend_own = 1'b0; pend_addr = '0;
        for (int c = 0; c < 100 && (exp_own.size() > 0 || pend); c++) begin
            @(posedge clk);
            #1;
            flush = 1'b0; dmd_req_valid = 1'b1; dmd_req_addr = cur_da;
            pf_req_valid = 1'b1; pf_req_addr = cur_pa; ic_req_ready = 1'b1;
            ic_rsp_valid = pend; ic_rsp_data = data_of(pend_addr);
            #4;
            if (pend) begin
                chk($sformatf("sb c%0d dmd_rsp_valid", c), dmd_rsp_valid, !pend_own);
                chk($sformatf("sb c%0d pf_done", c), pf_done, pend_own);
                if (dmd_rsp_valid && exp_dat.size() > 0)
                    chk($sformatf("sb c%0d data", c), dmd_rsp_data, exp_dat.pop_front());
                pend = 1'b0;
            end
            if (ic_req_valid && ic_req_ready) begin
                if (exp_own.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb c%0d extra grant: got addr %0h expected none", c, ic_req_addr);
                end else begin
                    o = exp_own.pop_front();
                    chk($sformatf("sb c%0d grant addr", c), ic_req_addr, o ? cur_pa : cur_da);
                    pend_addr = o ? cur_pa : cur_da;
                    if (!o) exp_dat.push_back(data_of(cur_da));
                    pend = 1'b1; pend_own = o;
                    if (dmd_req_ready) cur_da = cur_da + 32'h40;
                    if (pf_req_ready) cur_pa = cur_pa + 32'h40;
                end
            end
        end
        chk("sb grants outstanding", exp_own.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
